// File: rtl/ysyx_041514_ram_rd_bridge.sv
// Cache-port read responder: turns one held cache read request into a single AXI4 INCR
// read burst and hands each returned beat back as a one-cycle ready pulse.
module ysyx_041514_ram_rd_bridge #(
  parameter logic [3:0]  AXI_ID = 4'd0,
  parameter int unsigned ADDR_W = 32,
  parameter int unsigned DATA_W = 64
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [ADDR_W-1:0] ram_raddr_i,
  input  logic              ram_raddr_valid_i,
  input  logic [7:0]        ram_rmask_i,
  input  logic [3:0]        ram_rsize_i,
  input  logic [7:0]        ram_rlen_i,
  output logic              ram_rdata_ready_o,
  output logic [DATA_W-1:0] ram_rdata_o,
  output logic              axi_arvalid_o,
  input  logic              axi_arready_i,
  output logic [ADDR_W-1:0] axi_araddr_o,
  output logic [7:0]        axi_arlen_o,
  output logic [2:0]        axi_arsize_o,
  output logic [1:0]        axi_arburst_o,
  output logic [3:0]        axi_arid_o,
  input  logic              axi_rvalid_i,
  output logic              axi_rready_o,
  input  logic [DATA_W-1:0] axi_rdata_i,
  input  logic [1:0]        axi_rresp_i,
  input  logic              axi_rlast_i,
  input  logic [3:0]        axi_rid_i,
  output logic              resp_err_o,
  output logic              proto_err_o
);

  localparam int unsigned LEN_W = 8;
  localparam int unsigned CNT_W = LEN_W + 1;
  localparam logic [1:0]  BURST_INCR = 2'b01;

  typedef enum logic [2:0] {
    S_IDLE,
    S_AR,
    S_R,
    S_PAD,
    S_DRAIN,
    S_DONE
  } state_t;

  state_t           state;
  logic [CNT_W-1:0] cnt;

  logic [2:0] size_c;
  logic       size_bad_c;
  logic       r_hs_c;
  logic       last_beat_c;
  logic       beat_resp_bad_c;
  logic       beat_id_bad_c;
  logic       unused_rmask;

  assign axi_arburst_o = BURST_INCR;
  assign axi_arid_o    = AXI_ID;
  assign unused_rmask  = ^ram_rmask_i;

  // One-hot byte count to AXI size; unknown codes fall back to a full-width beat.
  always_comb begin
    size_c     = 3'd3;
    size_bad_c = 1'b0;
    case (ram_rsize_i)
      4'b0001: size_c = 3'd0;
      4'b0010: size_c = 3'd1;
      4'b0100: size_c = 3'd2;
      4'b1000: size_c = 3'd3;
      default: size_bad_c = 1'b1;
    endcase
  end

  assign r_hs_c          = axi_rvalid_i & axi_rready_o;
  assign last_beat_c     = (cnt == CNT_W'(axi_arlen_o));
  assign beat_resp_bad_c = (axi_rresp_i != 2'b00);
  assign beat_id_bad_c   = (axi_rid_i != AXI_ID);

  // cnt is the index of the next beat to be delivered to the cache port.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state             <= S_IDLE;
      cnt               <= '0;
      ram_rdata_ready_o <= 1'b0;
      ram_rdata_o       <= '0;
      axi_arvalid_o     <= 1'b0;
      axi_araddr_o      <= '0;
      axi_arlen_o       <= '0;
      axi_arsize_o      <= '0;
      axi_rready_o      <= 1'b0;
      resp_err_o        <= 1'b0;
      proto_err_o       <= 1'b0;
    end else begin
      ram_rdata_ready_o <= 1'b0;
      case (state)
        S_IDLE: begin
          if (ram_raddr_valid_i) begin
            axi_araddr_o  <= ram_raddr_i;
            axi_arlen_o   <= ram_rlen_i;
            axi_arsize_o  <= size_c;
            axi_arvalid_o <= 1'b1;
            cnt           <= '0;
            if (size_bad_c) proto_err_o <= 1'b1;
            state         <= S_AR;
          end
        end

        S_AR: begin
          if (axi_arready_i) begin
            axi_arvalid_o <= 1'b0;
            axi_rready_o  <= 1'b1;
            state         <= S_R;
          end
        end

        // rready drops for the pulse cycle so at most one beat is ever pending delivery.
        S_R: begin
          if (r_hs_c) begin
            ram_rdata_o       <= axi_rdata_i;
            ram_rdata_ready_o <= 1'b1;
            axi_rready_o      <= 1'b0;
            cnt               <= cnt + CNT_W'(1);
            if (beat_resp_bad_c) resp_err_o <= 1'b1;
            if (beat_id_bad_c) proto_err_o <= 1'b1;
            if (axi_rlast_i) begin
              if (last_beat_c) begin
                state <= S_DONE;
              end else begin
                proto_err_o <= 1'b1;
                state       <= S_PAD;
              end
            end else if (last_beat_c) begin
              proto_err_o <= 1'b1;
              state       <= S_DRAIN;
            end
          end else if (!axi_rready_o) begin
            axi_rready_o <= 1'b1;
          end
        end

        // Burst ended early: fill the requester's remaining beats with zeros.
        S_PAD: begin
          ram_rdata_o       <= '0;
          ram_rdata_ready_o <= 1'b1;
          cnt               <= cnt + CNT_W'(1);
          if (last_beat_c) state <= S_DONE;
        end

        // Requester already has all its beats: swallow the overrun until RLAST.
        S_DRAIN: begin
          if (r_hs_c) begin
            if (beat_resp_bad_c) resp_err_o <= 1'b1;
            if (beat_id_bad_c) proto_err_o <= 1'b1;
            if (axi_rlast_i) begin
              axi_rready_o <= 1'b0;
              state        <= S_DONE;
            end
          end else begin
            axi_rready_o <= 1'b1;
          end
        end

        // Wait out the final pulse plus one quiet cycle so a stale valid is not re-sampled.
        S_DONE: begin
          if (!ram_rdata_ready_o) state <= S_IDLE;
        end

        default: state <= S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_ysyx_041514_ram_rd_bridge.sv
// Bench for ysyx_041514_ram_rd_bridge: directed and randomized bursts from an AXI slave model,
// checked against a per-transaction list of expected pulses and sticky error flags.
module tb_ysyx_041514_ram_rd_bridge;

  localparam logic [3:0]  AXI_ID = 4'd0;
  localparam int unsigned MAXB   = 64;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic [31:0] ram_raddr_i = '0;
  logic        ram_raddr_valid_i = 1'b0;
  logic [7:0]  ram_rmask_i = '0;
  logic [3:0]  ram_rsize_i = '0;
  logic [7:0]  ram_rlen_i = '0;
  logic        ram_rdata_ready_o;
  logic [63:0] ram_rdata_o;
  logic        axi_arvalid_o;
  logic        axi_arready_i = 1'b0;
  logic [31:0] axi_araddr_o;
  logic [7:0]  axi_arlen_o;
  logic [2:0]  axi_arsize_o;
  logic [1:0]  axi_arburst_o;
  logic [3:0]  axi_arid_o;
  logic        axi_rvalid_i = 1'b0;
  logic        axi_rready_o;
  logic [63:0] axi_rdata_i = '0;
  logic [1:0]  axi_rresp_i = '0;
  logic        axi_rlast_i = 1'b0;
  logic [3:0]  axi_rid_i = '0;
  logic        resp_err_o;
  logic        proto_err_o;

  always #5 clk = ~clk;

  ysyx_041514_ram_rd_bridge #(
    .AXI_ID(AXI_ID),
    .ADDR_W(32),
    .DATA_W(64)
  ) dut (
    .clk              (clk),
    .rst              (rst),
    .ram_raddr_i      (ram_raddr_i),
    .ram_raddr_valid_i(ram_raddr_valid_i),
    .ram_rmask_i      (ram_rmask_i),
    .ram_rsize_i      (ram_rsize_i),
    .ram_rlen_i       (ram_rlen_i),
    .ram_rdata_ready_o(ram_rdata_ready_o),
    .ram_rdata_o      (ram_rdata_o),
    .axi_arvalid_o    (axi_arvalid_o),
    .axi_arready_i    (axi_arready_i),
    .axi_araddr_o     (axi_araddr_o),
    .axi_arlen_o      (axi_arlen_o),
    .axi_arsize_o     (axi_arsize_o),
    .axi_arburst_o    (axi_arburst_o),
    .axi_arid_o       (axi_arid_o),
    .axi_rvalid_i     (axi_rvalid_i),
    .axi_rready_o     (axi_rready_o),
    .axi_rdata_i      (axi_rdata_i),
    .axi_rresp_i      (axi_rresp_i),
    .axi_rlast_i      (axi_rlast_i),
    .axi_rid_i        (axi_rid_i),
    .resp_err_o       (resp_err_o),
    .proto_err_o      (proto_err_o)
  );

  int   n_cmp = 0;
  int   n_bad = 0;
  logic m_resp = 1'b0;
  logic m_proto = 1'b0;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_bad++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic bit size_ok(input logic [3:0] sz);
    return sz inside {4'b0001, 4'b0010, 4'b0100, 4'b1000};
  endfunction

  // AXI size is log2 of the byte count; anything unrecognised is treated as 8 bytes.
  function automatic logic [2:0] size_of(input logic [3:0] sz);
    if (size_ok(sz)) return 3'($clog2(sz));
    return 3'd3;
  endfunction

  task automatic chk_reset_state(input string tag);
    chk({tag, "_pulse"},   64'(ram_rdata_ready_o), 64'd0);
    chk({tag, "_rdata"},   ram_rdata_o,            64'd0);
    chk({tag, "_arvalid"}, 64'(axi_arvalid_o),     64'd0);
    chk({tag, "_araddr"},  64'(axi_araddr_o),      64'd0);
    chk({tag, "_arlen"},   64'(axi_arlen_o),       64'd0);
    chk({tag, "_arsize"},  64'(axi_arsize_o),      64'd0);
    chk({tag, "_rready"},  64'(axi_rready_o),      64'd0);
    chk({tag, "_resp"},    64'(resp_err_o),        64'd0);
    chk({tag, "_proto"},   64'(proto_err_o),       64'd0);
    chk({tag, "_arburst"}, 64'(axi_arburst_o),     64'd1);
    chk({tag, "_arid"},    64'(axi_arid_o),        64'(AXI_ID));
  endtask

  // One request: nbeats AXI beats with RLAST on the final one; the requester expects len+1.
  task automatic do_txn(input logic [31:0] addr, input logic [3:0] sz, input logic [7:0] len,
                        input int ar_dly, input int nbeats, input int gap_mode, input bit pat,
                        input int resp_bad, input int id_bad, input int rst_beat,
                        input int exp_ar_lat);
    logic [63:0] data [MAXB];
    logic [63:0] exp_q [$];
    int n_exp, ndel, beats, got, ar_state, ar_seen, idle_left, pad_left;
    bit expect_next, req, taken, finished;

    n_exp = int'(len) + 1;
    for (int i = 0; i < nbeats; i++)
      data[i] = pat ? 64'(64'h11 * (i + 1)) : {$urandom(), $urandom()};
    ndel = (nbeats < n_exp) ? nbeats : n_exp;
    for (int i = 0; i < ndel; i++) exp_q.push_back(data[i]);
    for (int i = ndel; i < n_exp; i++) exp_q.push_back(64'd0);
    if (nbeats != n_exp || id_bad >= 0 || !size_ok(sz)) m_proto = 1'b1;
    if (resp_bad >= 0 && resp_bad < nbeats) m_resp = 1'b1;

    @(negedge clk);
    ram_raddr_i       = addr;
    ram_rsize_i       = sz;
    ram_rlen_i        = len;
    ram_rmask_i       = 8'($urandom());
    ram_raddr_valid_i = 1'b1;

    beats = 0; got = 0; ar_state = 0; ar_seen = 0; idle_left = 0; pad_left = 0;
    expect_next = 1'b0; taken = 1'b0; finished = 1'b0;

    for (int cyc = 1; cyc <= 2000 && !finished; cyc++) begin
      @(negedge clk);
      req = expect_next;
      expect_next = 1'b0;
      chk("pulse_timing", 64'(ram_rdata_ready_o), 64'(req));
      if (req) begin
        chk("rready_in_pulse", 64'(axi_rready_o), 64'd0);
        if (exp_q.size() > 0) chk("pulse_data", ram_rdata_o, exp_q.pop_front());
        got++;
        if (got == n_exp) ram_raddr_valid_i = 1'b0;
        if (pad_left > 0) begin
          expect_next = 1'b1;
          pad_left--;
        end
      end

      if (rst_beat >= 0 && beats == rst_beat) begin
        chk("resp_err_pre_rst", 64'(resp_err_o), 64'(m_resp));
        #2 rst = 1'b0;
        #1;
        m_resp  = 1'b0;
        m_proto = 1'b0;
        chk_reset_state("async_rst");
        ram_raddr_valid_i = 1'b0;
        axi_rvalid_i      = 1'b0;
        axi_arready_i     = 1'b0;
        return;
      end

      if (ar_state == 1) begin
        ar_state      = 2;
        axi_arready_i = 1'b0;
        chk("arvalid_drop", 64'(axi_arvalid_o), 64'd0);
      end else if (ar_state == 0) begin
        if (axi_arvalid_o) begin
          ar_seen++;
          if (ar_seen == 1) chk("ar_latency", 64'(cyc), 64'(exp_ar_lat));
          chk("araddr", 64'(axi_araddr_o), 64'(addr));
          chk("arlen",  64'(axi_arlen_o),  64'(len));
          chk("arsize", 64'(axi_arsize_o), 64'(size_of(sz)));
          if (ar_seen > ar_dly) begin
            axi_arready_i = 1'b1;
            ar_state      = 1;
          end
        end else if (ar_seen > 0) begin
          chk("arvalid_held", 64'(axi_arvalid_o), 64'd1);
        end
      end

      if (ar_state == 2) begin
        if (taken) begin
          axi_rvalid_i = 1'b0;
          taken        = 1'b0;
        end
        if (!axi_rvalid_i && beats < nbeats) begin
          if (idle_left > 0) begin
            idle_left--;
          end else begin
            axi_rvalid_i = 1'b1;
            axi_rdata_i  = data[beats];
            axi_rlast_i  = (beats == nbeats - 1);
            axi_rresp_i  = (beats == resp_bad) ? 2'b10 : 2'b00;
            axi_rid_i    = (beats == id_bad) ? 4'h5 : AXI_ID;
          end
        end
        if (axi_rvalid_i && axi_rready_o) begin
          if (beats <= int'(len)) expect_next = 1'b1;
          if (axi_rlast_i && beats < int'(len)) pad_left = int'(len) - beats;
          beats++;
          taken     = 1'b1;
          idle_left = (gap_mode == 2) ? 2 : (gap_mode == 1) ? int'($urandom_range(0, 3)) : 0;
        end
      end

      if (got == n_exp && beats == nbeats && !axi_rvalid_i) finished = 1'b1;
    end

    chk("txn_completed", 64'(finished), 64'd1);
    chk("pulses_left", 64'(exp_q.size()), 64'd0);
    chk("resp_err", 64'(resp_err_o), 64'(m_resp));
    chk("proto_err", 64'(proto_err_o), 64'(m_proto));
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: observed=still_running expected=finished");
    $fatal(1, "watchdog expired");
  end

  initial begin
    logic [3:0] rsz;
    logic [7:0] rln;

    #3 rst = 1'b0;
    #1 chk_reset_state("reset");
    repeat (3) @(negedge clk);
    rst = 1'b1;

    // Line fill, then back-to-back requests that also probe the quiet cycle after each burst.
    do_txn(32'h8000_0040, 4'b1000, 8'd7, 0, 8, 0, 1'b1, -1, -1, -1, 1);
    do_txn(32'h1000_0004, 4'b0100, 8'd0, 5, 1, 0, 1'b0, -1, -1, -1, 2);
    do_txn($urandom() & 32'hFFFF_FFF8, 4'b1000, 8'd7, 1, 8, 2, 1'b0, -1, -1, -1, 2);

    for (int k = 0; k < 8; k++) begin
      rsz = 4'(4'b0001 << $urandom_range(0, 3));
      rln = 8'($urandom_range(0, 15));
      do_txn($urandom(), rsz, rln, int'($urandom_range(0, 3)), int'(rln) + 1, 1, 1'b0,
             -1, -1, -1, 2);
    end

    // Early RLAST on beat 3 of 8, then RLAST missing until two beats past the end.
    do_txn(32'h8000_1000, 4'b1000, 8'd7, 0, 3, 0, 1'b0, -1, -1, -1, 2);
    do_txn(32'h8000_2000, 4'b1000, 8'd3, 0, 6, 1, 1'b0, -1, -1, -1, 2);
    repeat (3) @(negedge clk);

    do_txn(32'h8000_3000, 4'b0011, 8'd1, 0, 2, 0, 1'b0, -1, -1, -1, 1);
    do_txn(32'h8000_4000, 4'b0010, 8'd2, 0, 3, 1, 1'b0, -1, 0, -1, 2);

    // Error response on beat 2, reset while beat 5 is in flight, then a clean request.
    do_txn(32'h8000_5000, 4'b1000, 8'd7, 0, 8, 0, 1'b0, 1, -1, 4, 2);
    repeat (2) @(negedge clk);
    rst = 1'b1;
    do_txn(32'h8000_6000, 4'b1000, 8'd3, 1, 4, 1, 1'b0, -1, -1, -1, 1);

    repeat (3) @(negedge clk);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
